// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transfer engine.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CS_SETUP = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_CS_HOLD  = 2'd3
  } spi_state_t;

  // SPI modes as {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Edge counter must hold 0..2*data_w without wrapping.
  function automatic int edge_cnt_w(input int data_w);
    return $clog2(2 * data_w + 1);
  endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Registers the baud-rate generator clock level and flags its leading/trailing toggles.
module spi_edge_detect #(
  parameter bit CPOL = 1'b0
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Baudclk,
  output logic baud_q,
  output logic lead,
  output logic trail
);

  always_ff @(posedge CLK) begin
    if (!RSTn) baud_q <= CPOL;
    else       baud_q <= Baudclk;
  end

  assign lead  = (Baudclk != baud_q) && (Baudclk != CPOL);
  assign trail = (Baudclk != baud_q) && (Baudclk == CPOL);

endmodule

// File: rtl/spi_master_shift.sv
// SPI master transfer engine: one full-duplex DATA_W-bit transfer per accepted Start,
// paced by the toggles of the external baud-rate generator clock.
//
// state       | meaning
// ST_IDLE     | CSn high, waiting for Start; Done pulses here after a transfer
// ST_CS_SETUP | CSn asserted one CLK before the generator is enabled
// ST_SHIFT    | generator running; count edges, sample MISO, drive MOSI
// ST_CS_HOLD  | one CLK of CSn hold after the last SCK edge
module spi_master_shift
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              Start,
  input  logic [DATA_W-1:0] Tx_data,
  output logic [DATA_W-1:0] Rx_data,
  output logic              Busy,
  output logic              Done,
  output logic              Baud_en,
  input  logic              Baudclk,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              CSn
);

  localparam int               CNT_W          = edge_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_M1        = CNT_W'(2 * DATA_W - 1);
  localparam logic [1:0]       MODE           = {CPOL, CPHA};
  localparam bit               SAMPLE_ON_LEAD = (MODE == MODE0) || (MODE == MODE2);

  spi_state_t        state;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [CNT_W-1:0]  edge_cnt;
  logic              baud_q;
  logic              lead;
  logic              trail;
  logic              sample_edge;
  logic              shift_edge;

  spi_edge_detect #(.CPOL(CPOL)) u_edge (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .Baudclk(Baudclk),
    .baud_q (baud_q),
    .lead   (lead),
    .trail  (trail)
  );

  assign sample_edge = SAMPLE_ON_LEAD ? lead  : trail;
  assign shift_edge  = SAMPLE_ON_LEAD ? trail : lead;

  assign SCK = ((state == ST_SHIFT) || (state == ST_CS_HOLD)) ? baud_q : CPOL;

  function automatic logic head(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state    <= ST_IDLE;
      CSn      <= 1'b1;
      MOSI     <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Baud_en  <= 1'b0;
      Rx_data  <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state    <= ST_CS_SETUP;
            CSn      <= 1'b0;
            Busy     <= 1'b1;
            edge_cnt <= '0;
            rx_sh    <= '0;
            // Leading-edge samplers need the first bit on MOSI before SCK moves.
            if (SAMPLE_ON_LEAD) begin
              MOSI  <= head(Tx_data);
              tx_sh <= advance(Tx_data);
            end else begin
              tx_sh <= Tx_data;
            end
          end
        end
        ST_CS_SETUP: begin
          state   <= ST_SHIFT;
          Baud_en <= 1'b1;
        end
        ST_SHIFT: begin
          if (lead || trail) begin
            edge_cnt <= edge_cnt + 1'b1;
            if (sample_edge)
              rx_sh <= MSB_FIRST ? {rx_sh[DATA_W-2:0], MISO} : {MISO, rx_sh[DATA_W-1:1]};
            if (shift_edge && (edge_cnt != LAST_M1)) begin
              MOSI  <= head(tx_sh);
              tx_sh <= advance(tx_sh);
            end
            if (edge_cnt == LAST_M1) begin
              Baud_en <= 1'b0;
              state   <= ST_CS_HOLD;
            end
          end
        end
        ST_CS_HOLD: begin
          state   <= ST_IDLE;
          CSn     <= 1'b1;
          Busy    <= 1'b0;
          Done    <= 1'b1;
          Rx_data <= rx_sh;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_shift.sv
// Bench for spi_master_shift: three DUT instances (mode0 MSB, mode3 MSB, mode0 LSB),
// each fed by a behavioural baud generator and an SPI slave / loopback model.
module tb_spi_master_shift;

  localparam int NI = 3;
  localparam logic [NI-1:0] P_CPOL = 3'b010;
  localparam logic [NI-1:0] P_CPHA = 3'b010;
  localparam logic [NI-1:0] P_MSB  = 3'b011;

  logic CLK = 1'b0;
  always #10 CLK = ~CLK;

  logic [NI-1:0] rstn  = '0;
  logic [NI-1:0] start = '0;
  logic [7:0]    tx [NI];
  logic [7:0]    rx [NI];
  logic [NI-1:0] busy, done, baud_en, sck, mosi, miso, csn;
  logic [NI-1:0] baudclk = P_CPOL;

  logic [7:0] slave_w [NI] = '{default: 8'h00};
  int         scaler  [NI] = '{default: 2};
  bit         loopb   [NI] = '{default: 1'b1};
  int         gcnt    [NI] = '{default: 0};

  int         nedge       [NI] = '{default: 0};
  int         leads       [NI] = '{default: 0};
  int         ncap        [NI] = '{default: 0};
  int         total_dones [NI] = '{default: 0};
  int         total_falls [NI] = '{default: 0};
  logic [7:0] cap         [NI] = '{default: 8'h00};
  logic       sck_prev    [NI] = '{1'b0, 1'b1, 1'b0};
  logic       csn_prev    [NI] = '{default: 1'b1};

  int nvec = 0;
  int nmis = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    spi_master_shift #(
      .DATA_W(8), .CPOL(P_CPOL[g]), .CPHA(P_CPHA[g]), .MSB_FIRST(P_MSB[g])
    ) u_dut (
      .CLK(CLK), .RSTn(rstn[g]), .Start(start[g]), .Tx_data(tx[g]), .Rx_data(rx[g]),
      .Busy(busy[g]), .Done(done[g]), .Baud_en(baud_en[g]), .Baudclk(baudclk[g]),
      .SCK(sck[g]), .MOSI(mosi[g]), .MISO(miso[g]), .CSn(csn[g])
    );
  end

  // Baud generator: held at CPOL while disabled, toggles every scaler CLKs when enabled.
  always @(posedge CLK) begin
    for (int g = 0; g < NI; g++) begin
      if (baud_en[g] !== 1'b1) begin
        gcnt[g]    <= 0;
        baudclk[g] <= P_CPOL[g];
      end else if (gcnt[g] >= scaler[g] - 1) begin
        gcnt[g]    <= 0;
        baudclk[g] <= ~baudclk[g];
      end else begin
        gcnt[g] <= gcnt[g] + 1;
      end
    end
  end

  // SPI bus observer / slave: counts SCK edges while selected and captures MOSI on sample edges.
  always @(negedge CLK) begin
    for (int g = 0; g < NI; g++) begin
      sck_prev[g] <= sck[g];
      csn_prev[g] <= csn[g];
      if (done[g] === 1'b1) total_dones[g] <= total_dones[g] + 1;
      if (csn_prev[g] && !csn[g]) begin
        total_falls[g] <= total_falls[g] + 1;
        nedge[g] <= 0;
        leads[g] <= 0;
        ncap[g]  <= 0;
        cap[g]   <= 8'h00;
      end else if (!csn[g] && (sck[g] != sck_prev[g])) begin
        nedge[g] <= nedge[g] + 1;
        if (sck[g] != P_CPOL[g]) leads[g] <= leads[g] + 1;
        if ((sck[g] != P_CPOL[g]) ^ P_CPHA[g]) begin
          if (P_MSB[g]) cap[g] <= {cap[g][6:0], mosi[g]};
          else if (ncap[g] < 8) cap[g][ncap[g]] <= mosi[g];
          ncap[g] <= ncap[g] + 1;
        end
      end
    end
  end

  // Slave presents transfer-order bit k after k shift edges (CPHA=0) or from the (k+1)-th lead (CPHA=1).
  always_comb begin
    int idx;
    idx  = 0;
    miso = '0;
    for (int g = 0; g < NI; g++) begin
      idx = P_CPHA[g] ? (nedge[g] - 1) / 2 : nedge[g] / 2;
      if (loopb[g]) miso[g] = mosi[g];
      else if (!csn[g] && idx >= 0 && idx <= 7)
        miso[g] = P_MSB[g] ? slave_w[g][7 - idx] : slave_w[g][idx];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int g, output bit ok, output logic bprev);
    ok = 1'b0;
    bprev = busy[g];
    for (int i = 0; i < 600; i++) begin
      bprev = busy[g];
      @(posedge CLK); #1;
      if (done[g]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic xfer(input int g, input logic [7:0] txw, input logic [7:0] sw, input bit lb,
                      input int sc, input string nm, input logic [7:0] exp_rx);
    int d0, f0;
    bit ok;
    logic bprev;
    d0 = total_dones[g];
    f0 = total_falls[g];
    scaler[g] = sc; loopb[g] = lb; slave_w[g] = sw; tx[g] = txw;
    start[g] = 1'b1;
    @(posedge CLK); #1;
    start[g] = 1'b0;
    check($sformatf("%s_csn_setup", nm), csn[g], 1'b0);
    check($sformatf("%s_busy_setup", nm), busy[g], 1'b1);
    if (P_CPHA[g] == 1'b0)
      check($sformatf("%s_mosi_first", nm), mosi[g], P_MSB[g] ? txw[7] : txw[0]);
    wait_done(g, ok, bprev);
    check($sformatf("%s_done_seen", nm), ok, 1'b1);
    check($sformatf("%s_rx", nm), rx[g], exp_rx);
    check($sformatf("%s_busy_at_done", nm), busy[g], 1'b0);
    check($sformatf("%s_busy_before_done", nm), bprev, 1'b1);
    check($sformatf("%s_csn_at_done", nm), csn[g], 1'b1);
    check($sformatf("%s_sck_idle", nm), sck[g], P_CPOL[g]);
    check($sformatf("%s_slave_cap", nm), cap[g], txw);
    check($sformatf("%s_edges", nm), nedge[g], 16);
    check($sformatf("%s_sck_pulses", nm), leads[g], 8);
    @(posedge CLK); #1;
    check($sformatf("%s_done_pulse", nm), done[g], 1'b0);
    check($sformatf("%s_ndone", nm), total_dones[g] - d0, 1);
    check($sformatf("%s_ncs", nm), total_falls[g] - f0, 1);
  endtask

  typedef struct {
    int         inst;
    logic [7:0] txw;
    logic [7:0] sw;
    bit         lb;
    int         sc;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bit ok;
    logic bprev;
    int d0, f0, g;
    logic [7:0] t, s;
    bit lb;

    vecs[0] = '{0, 8'hA5, 8'h00, 1'b1, 2, 8'hA5};
    vecs[1] = '{1, 8'hF0, 8'h3C, 1'b0, 2, 8'h3C};
    vecs[2] = '{2, 8'h01, 8'h00, 1'b1, 1, 8'h01};
    vecs[3] = '{0, 8'h5C, 8'h96, 1'b0, 1, 8'h96};
    vecs[4] = '{1, 8'h3E, 8'h00, 1'b1, 3, 8'h3E};
    vecs[5] = '{2, 8'hC4, 8'hB2, 1'b0, 2, 8'hB2};
    for (int i = 0; i < NI; i++) tx[i] = 8'h00;

    rstn = '0;
    repeat (3) @(posedge CLK);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_csn%0d", i), csn[i], 1'b1);
      check($sformatf("rst_sck%0d", i), sck[i], P_CPOL[i]);
      check($sformatf("rst_mosi%0d", i), mosi[i], 1'b0);
      check($sformatf("rst_busy%0d", i), busy[i], 1'b0);
      check($sformatf("rst_done%0d", i), done[i], 1'b0);
      check($sformatf("rst_baud_en%0d", i), baud_en[i], 1'b0);
      check($sformatf("rst_rx%0d", i), rx[i], 8'h00);
    end
    rstn = '1;
    repeat (2) @(posedge CLK);
    #1;

    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i].inst, vecs[i].txw, vecs[i].sw, vecs[i].lb, vecs[i].sc,
           $sformatf("vec%0d", i), vecs[i].exp_rx);
      repeat (2) @(posedge CLK);
      #1;
    end

    // Start during SHIFT must be ignored.
    d0 = total_dones[0]; f0 = total_falls[0];
    scaler[0] = 2; loopb[0] = 1'b1; tx[0] = 8'h96; start[0] = 1'b1;
    @(posedge CLK); #1;
    start[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK); #1;
      if (nedge[0] >= 4) begin ok = 1'b1; break; end
    end
    check("ign_reach_shift", ok, 1'b1);
    tx[0] = 8'h11; start[0] = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    start[0] = 1'b0;
    wait_done(0, ok, bprev);
    check("ign_done_seen", ok, 1'b1);
    check("ign_rx", rx[0], 8'h96);
    check("ign_slave_cap", cap[0], 8'h96);
    check("ign_ncs", total_falls[0] - f0, 1);
    repeat (40) @(posedge CLK);
    #1;
    check("ign_ndone", total_dones[0] - d0, 1);
    check("ign_csn_idle", csn[0], 1'b1);

    // Start held across the Done cycle starts the next transfer immediately.
    tx[0] = 8'hC3; start[0] = 1'b1;
    @(posedge CLK); #1;
    start[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK); #1;
      if (nedge[0] >= 2) begin ok = 1'b1; break; end
    end
    check("b2b_reach_shift", ok, 1'b1);
    tx[0] = 8'h5A; start[0] = 1'b1;
    wait_done(0, ok, bprev);
    check("b2b_done1_seen", ok, 1'b1);
    check("b2b_rx1", rx[0], 8'hC3);
    check("b2b_csn_gap", csn[0], 1'b1);
    @(posedge CLK); #1;
    start[0] = 1'b0;
    check("b2b_csn_relow", csn[0], 1'b0);
    check("b2b_busy2", busy[0], 1'b1);
    wait_done(0, ok, bprev);
    check("b2b_done2_seen", ok, 1'b1);
    check("b2b_rx2", rx[0], 8'h5A);
    check("b2b_cap2", cap[0], 8'h5A);
    repeat (2) @(posedge CLK);
    #1;

    // Reset after the third SCK edge aborts without Done.
    d0 = total_dones[0];
    tx[0] = 8'hE7; start[0] = 1'b1;
    @(posedge CLK); #1;
    start[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK); #1;
      if (nedge[0] >= 3) begin ok = 1'b1; break; end
    end
    check("abort_reach_edge3", ok, 1'b1);
    rstn[0] = 1'b0;
    @(posedge CLK); #1;
    rstn[0] = 1'b1;
    check("abort_csn", csn[0], 1'b1);
    check("abort_sck", sck[0], P_CPOL[0]);
    check("abort_baud_en", baud_en[0], 1'b0);
    check("abort_busy", busy[0], 1'b0);
    check("abort_rx", rx[0], 8'h00);
    repeat (40) @(posedge CLK);
    #1;
    check("abort_no_done", total_dones[0] - d0, 0);
    xfer(0, 8'h81, 8'h00, 1'b1, 2, "abort_recover", 8'h81);

    // Randomized transfers against the reference: Rx is the looped-back Tx or the slave word.
    for (int n = 0; n < 24; n++) begin
      g  = int'($urandom_range(0, NI - 1));
      t  = 8'($urandom);
      s  = 8'($urandom);
      lb = 1'($urandom);
      xfer(g, t, s, lb, int'($urandom_range(1, 3)), $sformatf("rnd%0d", n), lb ? t : s);
      repeat (int'($urandom_range(1, 3))) @(posedge CLK);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
